// File: rtl/flash_burst_reader.sv
// flash_burst_reader: Avalon-MM burst read master for the flash data port.
// Splits a (start address, word count) request into bursts of at most MAX_BURST beats
// and delivers the returned words through an internal FIFO on a valid/ready stream.
module flash_burst_reader #(
    parameter int unsigned ADDR_W     = 19,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned BURST_W    = 4,
    parameter int unsigned FIFO_DEPTH = 16,
    parameter int unsigned LEN_W      = 16
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [ADDR_W-1:0]  req_addr,
    input  logic [LEN_W-1:0]   req_len,
    input  logic               abort,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [DATA_W-1:0]  out_data,
    output logic               busy,
    output logic               done,
    output logic               aborted,
    output logic [ADDR_W-1:0]  avmm_data_addr,
    output logic               avmm_data_read,
    output logic [BURST_W-1:0] avmm_data_burstcount,
    input  logic [DATA_W-1:0]  avmm_data_readdata,
    input  logic               avmm_data_waitrequest,
    input  logic               avmm_data_readdatavalid
);
    localparam int unsigned MAX_BURST = 2 ** (BURST_W - 1);
    localparam int unsigned PTR_W     = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W     = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_BEATS, S_FINISH} state_t;

    state_t             state;
    logic [ADDR_W-1:0]  addr_q;
    logic [LEN_W-1:0]   remaining;
    logic [BURST_W-1:0] blen_q;
    logic [BURST_W-1:0] beat_cnt;
    logic               abort_q;

    logic [DATA_W-1:0]  mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [CNT_W-1:0]   count;

    logic               abort_c;
    logic               push_c;
    logic               pop_c;
    logic               head_bypass_c;
    logic [BURST_W-1:0] blen_c;
    logic [CNT_W-1:0]   free_slots;
    logic [CNT_W-1:0]   count_nxt;
    logic [PTR_W-1:0]   rd_ptr_nxt;

    // Abort qualification, FIFO push/pop and next-burst sizing
    always_comb begin
        abort_c       = abort_q | (abort & (state != S_IDLE));
        push_c        = (state == S_BEATS) & avmm_data_readdatavalid & ~abort_c;
        pop_c         = out_valid & out_ready;
        blen_c        = (remaining >= LEN_W'(MAX_BURST)) ? BURST_W'(MAX_BURST)
                                                         : BURST_W'(remaining);
        free_slots    = CNT_W'(FIFO_DEPTH) - count;
        count_nxt     = count + CNT_W'(push_c) - CNT_W'(pop_c);
        rd_ptr_nxt    = rd_ptr + PTR_W'(pop_c);
        // A word written into an (effectively) empty FIFO becomes the new head directly
        head_bypass_c = push_c & (count == CNT_W'(pop_c));
    end

    // FIFO storage; written only by accepted read beats
    always_ff @(posedge clock) begin
        if (push_c) begin
            mem[wr_ptr] <= avmm_data_readdata;
        end
    end

    // FIFO pointers, fill count and registered head (flushed on abort)
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
            out_data  <= '0;
        end else if (abort_c) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            count     <= '0;
            out_valid <= 1'b0;
        end else begin
            if (push_c) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            rd_ptr    <= rd_ptr_nxt;
            count     <= count_nxt;
            out_valid <= (count_nxt != '0);
            out_data  <= head_bypass_c ? avmm_data_readdata : mem[rd_ptr_nxt];
        end
    end

    // Request sequencing: accept, issue bursts with slot reservation, count beats, finish
    always_ff @(posedge clock) begin
        if (reset) begin
            state                <= S_IDLE;
            req_ready            <= 1'b1;
            busy                 <= 1'b0;
            done                 <= 1'b0;
            aborted              <= 1'b0;
            abort_q              <= 1'b0;
            addr_q               <= '0;
            remaining            <= '0;
            blen_q               <= '0;
            beat_cnt             <= '0;
            avmm_data_addr       <= '0;
            avmm_data_read       <= 1'b0;
            avmm_data_burstcount <= '0;
        end else begin
            done <= 1'b0;
            if ((state != S_IDLE) && abort) begin
                abort_q <= 1'b1;
            end
            case (state)
                S_IDLE: begin
                    if (req_valid) begin
                        addr_q    <= req_addr;
                        remaining <= req_len;
                        aborted   <= 1'b0;
                        abort_q   <= 1'b0;
                        busy      <= 1'b1;
                        req_ready <= 1'b0;
                        state     <= (req_len == '0) ? S_FINISH : S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    if (avmm_data_read) begin
                        // A presented command stays stable until the slave takes it
                        if (!avmm_data_waitrequest) begin
                            avmm_data_read <= 1'b0;
                            beat_cnt       <= '0;
                            state          <= S_BEATS;
                        end
                    end else if (abort_c) begin
                        state <= S_FINISH;
                    end else if (free_slots >= CNT_W'(blen_c)) begin
                        avmm_data_read       <= 1'b1;
                        avmm_data_addr       <= addr_q;
                        avmm_data_burstcount <= blen_c;
                        blen_q               <= blen_c;
                    end
                end
                S_BEATS: begin
                    if (avmm_data_readdatavalid) begin
                        beat_cnt <= beat_cnt + BURST_W'(1);
                        if ((beat_cnt + BURST_W'(1)) == blen_q) begin
                            addr_q    <= addr_q + ADDR_W'(blen_q);
                            remaining <= remaining - LEN_W'(blen_q);
                            state     <= (abort_c || (remaining == LEN_W'(blen_q)))
                                         ? S_FINISH : S_ISSUE;
                        end
                    end
                end
                S_FINISH: begin
                    if (abort_c || (count == '0)) begin
                        done      <= 1'b1;
                        busy      <= 1'b0;
                        aborted   <= abort_c;
                        abort_q   <= 1'b0;
                        req_ready <= 1'b1;
                        state     <= S_IDLE;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_flash_burst_reader.sv
// tb_flash_burst_reader: table-driven requests plus directed corner cases, with an
// Avalon slave model, a burst-command scoreboard and an output-word scoreboard.
`timescale 1ns/1ps
module tb_flash_burst_reader;
    localparam int unsigned ADDR_W     = 19;
    localparam int unsigned DATA_W     = 32;
    localparam int unsigned BURST_W    = 4;
    localparam int unsigned FIFO_DEPTH = 16;
    localparam int unsigned LEN_W      = 16;
    localparam int          MAXB       = 8;

    logic               clock = 1'b0;
    logic               reset;
    logic               req_valid;
    logic               req_ready;
    logic [ADDR_W-1:0]  req_addr;
    logic [LEN_W-1:0]   req_len;
    logic               abort;
    logic               out_valid;
    logic               out_ready;
    logic [DATA_W-1:0]  out_data;
    logic               busy;
    logic               done;
    logic               aborted;
    logic [ADDR_W-1:0]  avmm_data_addr;
    logic               avmm_data_read;
    logic [BURST_W-1:0] avmm_data_burstcount;
    logic [DATA_W-1:0]  avmm_data_readdata;
    logic               avmm_data_waitrequest;
    logic               avmm_data_readdatavalid;

    flash_burst_reader #(
        .ADDR_W(ADDR_W), .DATA_W(DATA_W), .BURST_W(BURST_W),
        .FIFO_DEPTH(FIFO_DEPTH), .LEN_W(LEN_W)
    ) dut (
        .clock(clock), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr), .req_len(req_len),
        .abort(abort),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .busy(busy), .done(done), .aborted(aborted),
        .avmm_data_addr(avmm_data_addr), .avmm_data_read(avmm_data_read),
        .avmm_data_burstcount(avmm_data_burstcount),
        .avmm_data_readdata(avmm_data_readdata),
        .avmm_data_waitrequest(avmm_data_waitrequest),
        .avmm_data_readdatavalid(avmm_data_readdatavalid)
    );

    always #5 clock = ~clock;

    int cyc = 0;
    always @(posedge clock) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;

    typedef struct packed {
        logic [ADDR_W-1:0]  addr;
        logic [BURST_W-1:0] bc;
    } burst_t;

    typedef struct {
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
        bit                throttle;
        int                nbursts;
    } vec_t;

    burst_t            exp_bursts[$];
    logic [DATA_W-1:0] exp_words[$];

    int     bursts_seen   = 0;
    int     beats_driven  = 0;
    int     pops          = 0;
    int     done_cnt      = 0;
    int     done_cyc      = 0;
    int     last_pop_cyc  = 0;
    int     last_beat_cyc = 0;
    int     stall_left    = 0;
    int     stall_seen    = 0;
    int     pending       = 0;
    logic   done_aborted  = 1'b0;
    logic   stalling      = 1'b0;
    burst_t stall_cmd;
    burst_t mon_b;
    logic [ADDR_W-1:0] beat_addr;

    function automatic logic [DATA_W-1:0] word_of(input logic [ADDR_W-1:0] a);
        return 32'hC0DE_0000 ^ DATA_W'(a);
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference split of a request into expected bursts and expected words
    task automatic expect_req(input logic [ADDR_W-1:0] a, input int len);
        logic [ADDR_W-1:0] p;
        int                rem;
        int                b;
        burst_t            eb;
        p   = a;
        rem = len;
        for (int i = 0; i < len; i++) exp_words.push_back(word_of(ADDR_W'(a + i)));
        while (rem > 0) begin
            b       = (rem > MAXB) ? MAXB : rem;
            eb.addr = p;
            eb.bc   = BURST_W'(b);
            exp_bursts.push_back(eb);
            p   = ADDR_W'(p + b);
            rem = rem - b;
        end
    endtask

    // Slave model, consumer monitor and done monitor, all evaluated mid-cycle
    initial begin
        avmm_data_waitrequest   = 1'b0;
        avmm_data_readdatavalid = 1'b0;
        avmm_data_readdata      = '0;
        beat_addr               = '0;
        forever begin
            @(negedge clock);
            if (pending > 0) begin
                avmm_data_readdatavalid = 1'b1;
                avmm_data_readdata      = word_of(beat_addr);
                beat_addr               = ADDR_W'(beat_addr + 1);
                pending--;
                beats_driven++;
                last_beat_cyc = cyc;
            end else begin
                avmm_data_readdatavalid = 1'b0;
            end
            avmm_data_waitrequest = 1'b0;
            if (!reset && avmm_data_read) begin
                if (stalling) check("stall_hold", 64'({avmm_data_addr, avmm_data_burstcount}), 64'(stall_cmd));
                if (stall_left > 0) begin
                    if (!stalling) begin
                        stalling  = 1'b1;
                        stall_cmd = {avmm_data_addr, avmm_data_burstcount};
                    end
                    avmm_data_waitrequest = 1'b1;
                    stall_left--;
                    stall_seen++;
                end else begin
                    stalling = 1'b0;
                    bursts_seen++;
                    if (exp_bursts.size() == 0) begin
                        checks++;
                        errors++;
                        $display("FAIL burst_unexpected: got addr 0x%0h count %0d, none required",
                                 avmm_data_addr, avmm_data_burstcount);
                    end else begin
                        mon_b = exp_bursts.pop_front();
                        check("burst_cmd", 64'({avmm_data_addr, avmm_data_burstcount}), 64'(mon_b));
                    end
                    pending   = int'(avmm_data_burstcount);
                    beat_addr = avmm_data_addr;
                end
            end
            if (!reset && out_valid && out_ready) begin
                pops++;
                last_pop_cyc = cyc;
                if (exp_words.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL word_unexpected: got 0x%0h, none required", out_data);
                end else begin
                    check("out_word", 64'(out_data), 64'(exp_words.pop_front()));
                end
            end
            if (!reset && done) begin
                done_cnt++;
                done_cyc     = cyc;
                done_aborted = aborted;
            end
        end
    end

    task automatic issue(input logic [ADDR_W-1:0] a, input logic [LEN_W-1:0] len, output int acc);
        check("req_ready_idle", 64'(req_ready), 64'(1));
        req_valid = 1'b1;
        req_addr  = a;
        req_len   = len;
        acc       = cyc;
        @(posedge clock); #1;
        req_valid = 1'b0;
        check("busy_after_accept", 64'(busy), 64'(1));
    endtask

    task automatic wait_done(input int start, input int budget, input bit throttle);
        int n;
        n = 0;
        while (done_cnt == start && n < budget) begin
            if (throttle) out_ready = 1'($urandom_range(0, 1));
            @(posedge clock); #1;
            n++;
        end
        check("done_pulse", 64'(done_cnt - start), 64'(1));
        check("busy_after_done", 64'(busy), 64'(0));
        check("req_ready_after_done", 64'(req_ready), 64'(1));
    endtask

    vec_t vecs[7];
    int   acc, b0, d0, p0, k0, n;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{19'h00100, 16'd20, 1'b0, 3};
        vecs[1] = '{19'h7FFFC, 16'd8,  1'b0, 1};
        vecs[2] = '{19'h7FFFC, 16'd12, 1'b0, 2};
        vecs[3] = '{19'h00040, 16'd5,  1'b1, 1};
        vecs[4] = '{19'h01000, 16'd17, 1'b1, 3};
        vecs[5] = '{19'h7FFF0, 16'd33, 1'b1, 5};
        vecs[6] = '{19'h00ABC, 16'd0,  1'b0, 0};

        reset     = 1'b1;
        req_valid = 1'b0;
        req_addr  = '0;
        req_len   = '0;
        abort     = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b0;
        check("rst_req_ready", 64'(req_ready), 64'(1));
        check("rst_read", 64'(avmm_data_read), 64'(0));
        check("rst_addr", 64'(avmm_data_addr), 64'(0));
        check("rst_burstcount", 64'(avmm_data_burstcount), 64'(0));
        check("rst_out_valid", 64'(out_valid), 64'(0));
        check("rst_busy", 64'(busy), 64'(0));
        check("rst_done", 64'(done), 64'(0));
        check("rst_aborted", 64'(aborted), 64'(0));

        // Table-driven normal requests
        for (int i = 0; i < 7; i++) begin
            expect_req(vecs[i].addr, int'(vecs[i].len));
            out_ready = !vecs[i].throttle;
            b0 = bursts_seen;
            d0 = done_cnt;
            issue(vecs[i].addr, vecs[i].len, acc);
            wait_done(d0, 600, vecs[i].throttle);
            check($sformatf("v%0d_aborted", i), 64'(done_aborted), 64'(0));
            check($sformatf("v%0d_bursts", i), 64'(bursts_seen - b0), 64'(vecs[i].nbursts));
            check($sformatf("v%0d_words_left", i), 64'(exp_words.size()), 64'(0));
            check($sformatf("v%0d_bursts_left", i), 64'(exp_bursts.size()), 64'(0));
            // done rises on the clock edge right after the edge that took the last word
            if (vecs[i].len != '0)
                check($sformatf("v%0d_done_after_pop", i), 64'(done_cyc - last_pop_cyc), 64'(2));
            else
                check($sformatf("v%0d_done_after_accept", i), 64'(done_cyc - acc), 64'(2));
            repeat (2) @(posedge clock);
            #1;
        end

        // Backpressure: FIFO fills with two bursts, third waits for free slots
        out_ready = 1'b0;
        expect_req(19'h02000, 24);
        b0 = bursts_seen;
        d0 = done_cnt;
        issue(19'h02000, 16'd24, acc);
        repeat (40) @(posedge clock);
        #1;
        check("bp_bursts_while_full", 64'(bursts_seen - b0), 64'(2));
        check("bp_no_done", 64'(done_cnt - d0), 64'(0));
        check("bp_out_valid", 64'(out_valid), 64'(1));
        check("bp_req_ready", 64'(req_ready), 64'(0));
        out_ready = 1'b1;
        wait_done(d0, 300, 1'b0);
        check("bp_bursts_total", 64'(bursts_seen - b0), 64'(3));
        check("bp_words_left", 64'(exp_words.size()), 64'(0));

        // Slave stalls the first command for five cycles
        stall_seen = 0;
        stall_left = 5;
        expect_req(19'h00300, 8);
        d0 = done_cnt;
        issue(19'h00300, 16'd8, acc);
        wait_done(d0, 300, 1'b0);
        check("stall_cycles", 64'(stall_seen), 64'(5));
        check("stall_words_left", 64'(exp_words.size()), 64'(0));

        // Abort two beats into the first burst of a 24-word request
        out_ready = 1'b0;
        begin
            burst_t eb;
            eb.addr = 19'h00400;
            eb.bc   = 4'd8;
            exp_bursts.push_back(eb);
        end
        b0 = bursts_seen;
        d0 = done_cnt;
        p0 = pops;
        k0 = beats_driven;
        issue(19'h00400, 16'd24, acc);
        n = 0;
        while (beats_driven - k0 < 2 && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        check("ab_two_beats", 64'(beats_driven - k0), 64'(2));
        check("ab_valid_before", 64'(out_valid), 64'(1));
        abort = 1'b1;
        @(posedge clock); #1;
        abort = 1'b0;
        check("ab_valid_cleared", 64'(out_valid), 64'(0));
        wait_done(d0, 300, 1'b0);
        check("ab_aborted", 64'(done_aborted), 64'(1));
        check("ab_aborted_held", 64'(aborted), 64'(1));
        check("ab_after_last_beat", 64'(done_cyc - last_beat_cyc), 64'(2));
        check("ab_pending", 64'(pending), 64'(0));
        repeat (10) @(posedge clock);
        #1;
        check("ab_bursts", 64'(bursts_seen - b0), 64'(1));
        check("ab_pops", 64'(pops - p0), 64'(0));
        check("ab_out_valid", 64'(out_valid), 64'(0));

        // Zero-length request right after an abort
        b0 = bursts_seen;
        d0 = done_cnt;
        issue(19'h00500, 16'd0, acc);
        wait_done(d0, 20, 1'b0);
        check("z_done_latency", 64'(done_cyc - acc), 64'(2));
        check("z_aborted", 64'(done_aborted), 64'(0));
        check("z_bursts", 64'(bursts_seen - b0), 64'(0));

        // Reset in the middle of a burst; stray beats afterwards are ignored
        out_ready = 1'b1;
        expect_req(19'h00600, 20);
        d0 = done_cnt;
        k0 = beats_driven;
        issue(19'h00600, 16'd20, acc);
        n = 0;
        while (beats_driven - k0 < 3 && n < 60) begin
            @(posedge clock); #1;
            n++;
        end
        reset = 1'b1;
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;
        exp_words.delete();
        exp_bursts.delete();
        check("mr_req_ready", 64'(req_ready), 64'(1));
        check("mr_read", 64'(avmm_data_read), 64'(0));
        check("mr_busy", 64'(busy), 64'(0));
        check("mr_out_valid", 64'(out_valid), 64'(0));
        n = 0;
        while (pending > 0 && n < 20) begin
            @(posedge clock); #1;
            n++;
        end
        repeat (2) @(posedge clock);
        #1;
        check("mr_stray_ignored", 64'(out_valid), 64'(0));
        check("mr_no_done", 64'(done_cnt - d0), 64'(0));
        expect_req(19'h00700, 4);
        d0 = done_cnt;
        issue(19'h00700, 16'd4, acc);
        wait_done(d0, 100, 1'b0);
        check("mr_recover_words", 64'(exp_words.size()), 64'(0));

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
